alien_march_ctrl: RTL and testbench
===================================

ALIEN_MARCH_CTRL -- requirements
Module: alien_march_ctrl

Interface
REQ-001 SHALL have parameter START_ROW, default 40: fleet origin row after reset.
REQ-002 SHALL have parameter START_COL, default 20: fleet origin column after reset.
REQ-003 SHALL have parameter STEP_X, default 10: horizontal pixels per march step.
REQ-004 SHALL have parameter STEP_Y, default 10: vertical pixels per step-down.
REQ-005 SHALL have parameter SCREEN_W, default 640: exclusive right screen bound.
REQ-006 SHALL have parameter LAND_ROW, default 420: fleet bottom row that ends the game.
REQ-007 SHALL have parameter MIN_PERIOD, default 250000: tick period in cycles with zero aliens alive.
REQ-008 SHALL have parameter PERIOD_PER_ALIEN, default 50000: cycles added per live alien.
REQ-009 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-010 SHALL have port Reset, input, 1 bit: synchronous, active-high.
REQ-011 SHALL have port Start, input, 1 bit: begins the march from IDLE.
REQ-012 SHALL have port Aliens_Grid, input, 50 bits: live mask; bit i*10+j = fleet row i (0..4), fleet column j (0..9).
REQ-013 SHALL have port Aliens_Row, output, 9 bits: top row of fleet row 0.
REQ-014 SHALL have port Aliens_Col, output, 10 bits: left column of fleet column 0.
REQ-015 SHALL have port Direction, output, 1 bit: 0 = moving right, 1 = moving left.
REQ-016 SHALL have port March_Tick, output, 1 bit: one-cycle pulse, high in the cycle after each position update.
REQ-017 SHALL have port Aliens_Landed, output, 1 bit: sticky; fleet has reached LAND_ROW.

Function
REQ-018 Geometry SHALL be fixed: alien 30 wide and 20 high, column pitch 40, row pitch 30.
REQ-019 SHALL derive combinationally from Aliens_Grid: Lc/Rc = leftmost/rightmost column with any live bit, Br = lowest row with any live bit, Alive = popcount (6 bits).
REQ-020 Period SHALL be MIN_PERIOD + PERIOD_PER_ALIEN*Alive, 24 bits, re-evaluated every cycle.
REQ-021 Edge and landing sums SHALL use 11-bit arithmetic (no 10-bit wrap).
REQ-022 FSM states SHALL be IDLE, MARCH_R, MARCH_L, HALT; reset state IDLE.
REQ-023 IDLE: Start=1 -> MARCH_R with cycle counter = 0; Start is ignored in every other state.
REQ-024 MARCH_*: counter increments each cycle; when counter >= Period-1, tick: counter <= 0 and position updates on that edge, i.e. P cycles after entry or after the previous tick when Period is constant.
REQ-025 Tick in MARCH_R: if Aliens_Col + 40*Rc + 30 + STEP_X <= SCREEN_W then Col += STEP_X; otherwise Row += STEP_Y, Col unchanged, state -> MARCH_L, Direction <= 1.
REQ-026 Tick in MARCH_L: if Aliens_Col + 40*Lc >= STEP_X then Col -= STEP_X; otherwise Row += STEP_Y, state -> MARCH_R, Direction <= 0.
REQ-027 After any step-down, if new Row + 30*Br + 20 >= LAND_ROW then state SHALL go to HALT and Aliens_Landed <= 1 on the same edge.
REQ-028 Aliens_Grid == 0 in any MARCH state SHALL force HALT on the next edge, with no move and Aliens_Landed staying 0; this takes priority over a coincident tick.
REQ-029 HALT SHALL freeze all outputs, with no further ticks, until Reset.
REQ-030 A Period shrink below the current counter value SHALL cause a tick on the next edge, never a wrap or skipped tick.

Reset
REQ-031 Reset SHALL set Aliens_Row=START_ROW, Aliens_Col=START_COL, Direction=0, March_Tick=0, Aliens_Landed=0, counter=0, and state IDLE.
REQ-032 Reset SHALL take precedence over every other event, including mid-march and in HALT.

Verification (MIN_PERIOD=4, PERIOD_PER_ALIEN=1; full grid gives P=54)
REQ-033 Reset with Start=0 for 100 cycles -> Row=40, Col=20, Direction=0, no March_Tick, Landed=0.
REQ-034 Full grid, Start pulse -> first move at edge 54 after accept: Col=30, March_Tick high exactly one cycle; next move 54 cycles later.
REQ-035 Full grid -> 23 right moves to Col=250; 24th tick gives Row=50, Col=250, Direction=1; 25th tick gives Col=240.
REQ-036 Full grid with LAND_ROW=190 -> 24th tick gives Row=50 and Aliens_Landed=1; FSM in HALT; no ticks over the next 500 cycles.
REQ-037 Only bit 0 alive (P=5) -> ticks every 5 cycles; right moves continue to Col=610, then step-down; clearing bit 0 mid-count -> HALT, Row/Col frozen, Landed=0.
REQ-038 Reset asserted mid-march (Col=120, Direction=1) -> next cycle Row=40, Col=20, Direction=0, IDLE; Start needed to resume.

Source files
------------

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: steps an invaders-style alien fleet across the screen.
// The fleet marches horizontally one step per tick. When it reaches a screen
// edge it steps down and reverses. The game ends when the lowest live row
// reaches the landing row. The tick period shrinks as aliens are destroyed.
//
// Ports:
//   Clk           - clock, all state updates on the rising edge
//   Reset         - synchronous, active-high
//   Start         - begins the march from IDLE
//   Aliens_Grid   - live mask, bit i*10+j = fleet row i, fleet column j
//   Aliens_Row    - top pixel row of fleet row 0
//   Aliens_Col    - left pixel column of fleet column 0
//   Direction     - 0 = moving right, 1 = moving left
//   March_Tick    - one-cycle pulse following every position update
//   Aliens_Landed - sticky flag, the fleet has reached LAND_ROW
module alien_march_ctrl #(
    parameter int unsigned START_ROW        = 40,
    parameter int unsigned START_COL        = 20,
    parameter int unsigned STEP_X           = 10,
    parameter int unsigned STEP_Y           = 10,
    parameter int unsigned SCREEN_W         = 640,
    parameter int unsigned LAND_ROW         = 420,
    parameter int unsigned MIN_PERIOD       = 250000,
    parameter int unsigned PERIOD_PER_ALIEN = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [49:0] Aliens_Grid,
    output logic [8:0]  Aliens_Row,
    output logic [9:0]  Aliens_Col,
    output logic        Direction,
    output logic        March_Tick,
    output logic        Aliens_Landed
);

    localparam int unsigned ROW_W = 9;
    localparam int unsigned COL_W = 10;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned SUM_W = 11;

    typedef enum logic [1:0] {IDLE, MARCH_R, MARCH_L, HALT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               dir_q, dir_d;
    logic               tick_q, tick_d;
    logic               landed_q, landed_d;

    logic [9:0]         col_any;
    logic [4:0]         row_any;
    logic [3:0]         lc, rc;
    logic [2:0]         br;
    logic [5:0]         alive;
    logic [CNT_W-1:0]   period;
    logic               grid_empty, tick_now, fits_r, fits_l, land_hit;

    // Fleet extents and population from the live mask.
    always_comb begin
        col_any = '0;
        row_any = '0;
        alive   = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 10; j++) begin
                if (Aliens_Grid[i*10+j]) begin
                    col_any[j] = 1'b1;
                    row_any[i] = 1'b1;
                end
                alive = alive + 6'(Aliens_Grid[i*10+j]);
            end
        end
        lc = '0;
        for (int j = 9; j >= 0; j--) begin
            if (col_any[j]) lc = 4'(j);
        end
        rc = '0;
        for (int j = 0; j < 10; j++) begin
            if (col_any[j]) rc = 4'(j);
        end
        br = '0;
        for (int i = 0; i < 5; i++) begin
            if (row_any[i]) br = 3'(i);
        end
    end

    assign period     = CNT_W'(MIN_PERIOD) + CNT_W'(PERIOD_PER_ALIEN) * CNT_W'(alive);
    assign grid_empty = (Aliens_Grid == '0);
    // Compared as cnt+1 >= period so a shrunken period ticks immediately and a
    // zero period cannot underflow.
    assign tick_now   = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) >= (CNT_W+1)'(period);
    assign fits_r     = (SUM_W'(col_q) + SUM_W'(40) * SUM_W'(rc) + SUM_W'(30)
                         + SUM_W'(STEP_X)) <= SUM_W'(SCREEN_W);
    assign fits_l     = (SUM_W'(col_q) + SUM_W'(40) * SUM_W'(lc)) >= SUM_W'(STEP_X);
    // Bottom of the lowest live row after the pending step-down.
    assign land_hit   = (SUM_W'(row_q) + SUM_W'(STEP_Y) + SUM_W'(30) * SUM_W'(br)
                         + SUM_W'(20)) >= SUM_W'(LAND_ROW);

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            row_q    <= ROW_W'(START_ROW);
            col_q    <= COL_W'(START_COL);
            dir_q    <= 1'b0;
            tick_q   <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dir_q    <= dir_d;
            tick_q   <= tick_d;
            landed_q <= landed_d;
        end
    end

    // Next state and tick counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = MARCH_R;
                    cnt_d   = '0;
                end
            end
            MARCH_R, MARCH_L: begin
                if (grid_empty) begin
                    state_d = HALT;
                end else if (tick_now) begin
                    cnt_d = '0;
                    if (state_q == MARCH_R && !fits_r) begin
                        state_d = land_hit ? HALT : MARCH_L;
                    end else if (state_q == MARCH_L && !fits_l) begin
                        state_d = land_hit ? HALT : MARCH_R;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Position, direction, tick pulse and landing flag updates.
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        dir_d    = dir_q;
        tick_d   = 1'b0;
        landed_d = landed_q;
        if ((state_q == MARCH_R || state_q == MARCH_L) && !grid_empty && tick_now) begin
            tick_d = 1'b1;
            if (state_q == MARCH_R) begin
                if (fits_r) begin
                    col_d = col_q + COL_W'(STEP_X);
                end else begin
                    row_d    = row_q + ROW_W'(STEP_Y);
                    dir_d    = 1'b1;
                    landed_d = land_hit;
                end
            end else begin
                if (fits_l) begin
                    col_d = col_q - COL_W'(STEP_X);
                end else begin
                    row_d    = row_q + ROW_W'(STEP_Y);
                    dir_d    = 1'b0;
                    landed_d = land_hit;
                end
            end
        end
    end

    assign Aliens_Row    = row_q;
    assign Aliens_Col    = col_q;
    assign Direction     = dir_q;
    assign March_Tick    = tick_q;
    assign Aliens_Landed = landed_q;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Scoreboard bench for alien_march_ctrl. Two instances share stimulus: A uses
// the default landing row, B lands early (LAND_ROW=190). Expected tick events
// are queued when stimulus is issued and popped by per-instance monitors.
module tb_alien_march_ctrl;

    typedef struct {
        int unsigned cyc;
        int unsigned row;
        int unsigned col;
        bit          dir;
        bit          landed;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [49:0] grid = '0;

    logic [8:0]  a_row, b_row;
    logic [9:0]  a_col, b_col;
    logic        a_dir, b_dir, a_tick, b_tick, a_land, b_land;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        qa[$];
    exp_t        qb[$];

    alien_march_ctrl #(.MIN_PERIOD(4), .PERIOD_PER_ALIEN(1)) dut_a (
        .Clk(clk), .Reset(reset), .Start(start), .Aliens_Grid(grid),
        .Aliens_Row(a_row), .Aliens_Col(a_col), .Direction(a_dir),
        .March_Tick(a_tick), .Aliens_Landed(a_land)
    );

    alien_march_ctrl #(.MIN_PERIOD(4), .PERIOD_PER_ALIEN(1), .LAND_ROW(190)) dut_b (
        .Clk(clk), .Reset(reset), .Start(start), .Aliens_Grid(grid),
        .Aliens_Row(b_row), .Aliens_Col(b_col), .Direction(b_dir),
        .March_Tick(b_tick), .Aliens_Landed(b_land)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void cmp_evt(string nm, exp_t e, int unsigned c, int unsigned r,
                                    int unsigned cl, bit d, bit l);
        checks = checks + 1;
        if (e.cyc != c || e.row != r || e.col != cl || e.dir != d || e.landed != l) begin
            errors = errors + 1;
            $display("FAIL %s tick: got cyc=%0d row=%0d col=%0d dir=%0d landed=%0d, expected cyc=%0d row=%0d col=%0d dir=%0d landed=%0d",
                     nm, c, r, cl, d, l, e.cyc, e.row, e.col, e.dir, e.landed);
        end
    endfunction

    // Monitors: every March_Tick pulse must match the next queued event.
    always @(negedge clk) begin
        if (a_tick) begin
            if (qa.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL A unexpected_tick: got tick at cyc=%0d row=%0d col=%0d, expected none",
                         cyc, a_row, a_col);
            end else begin
                cmp_evt("A", qa.pop_front(), cyc, a_row, a_col, a_dir, a_land);
            end
        end
    end

    always @(negedge clk) begin
        if (b_tick) begin
            if (qb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL B unexpected_tick: got tick at cyc=%0d row=%0d col=%0d, expected none",
                         cyc, b_row, b_col);
            end else begin
                cmp_evt("B", qb.pop_front(), cyc, b_row, b_col, b_dir, b_land);
            end
        end
    end

    function automatic void push(bit to_a, bit to_b, int unsigned c, int unsigned r,
                                 int unsigned cl, bit d, bit la, bit lb);
        exp_t e;
        e.cyc = c; e.row = r; e.col = cl; e.dir = d;
        if (to_a) begin e.landed = la; qa.push_back(e); end
        if (to_b) begin e.landed = lb; qb.push_back(e); end
    endfunction

    function automatic void chk(string nm, int unsigned act, int unsigned exp_v);
        checks = checks + 1;
        if (act != exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endfunction

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk_pos(string nm, int unsigned r, int unsigned c, bit d, bit la, bit lb);
        chk({nm, " A row"}, a_row, r);
        chk({nm, " A col"}, a_col, c);
        chk({nm, " A dir"}, a_dir, d);
        chk({nm, " A landed"}, a_land, la);
        chk({nm, " B row"}, b_row, r);
        chk({nm, " B col"}, b_col, c);
        chk({nm, " B landed"}, b_land, lb);
    endtask

    // Pulses Start for one edge; returns the negedge cycle it was raised at.
    task automatic pulse_start(output int unsigned m);
        @(negedge clk);
        m = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int unsigned m;
        int unsigned t;

        // Reset, then idle with Start low: no movement, no ticks.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk_pos("idle", 40, 20, 1'b0, 1'b0, 1'b0);
        chk("idle A tick", a_tick, 0);

        // Full grid: P=54, 23 right moves, step-down, then left moves.
        grid = {50{1'b1}};
        pulse_start(m);
        for (int k = 1; k <= 23; k++)
            push(1, 1, m + 1 + 54*k, 40, 20 + 10*k, 1'b0, 1'b0, 1'b0);
        push(1, 1, m + 1 + 54*24, 50, 250, 1'b1, 1'b0, 1'b1);
        for (int k = 25; k <= 37; k++)
            push(1, 0, m + 1 + 54*k, 50, 250 - 10*(k - 24), 1'b1, 1'b0, 1'b0);
        t = m + 1 + 54*37;
        wait_cyc(t);
        // B landed long ago and must have stayed frozen.
        chk("landed B row", b_row, 50);
        chk("landed B col", b_col, 250);
        chk("landed B dir", b_dir, 1);
        chk("landed B flag", b_land, 1);
        chk("mid A col", a_col, 120);
        chk("mid A dir", a_dir, 1);

        // Reset mid-march: back to origin, idle until Start.
        reset = 1'b1;
        @(negedge clk);
        chk_pos("reset mid", 40, 20, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("post reset A col", a_col, 20);

        // Single alien at bit 0: P=5, right to 610, step-down, one left move.
        grid = 50'd1;
        pulse_start(m);
        for (int k = 1; k <= 59; k++)
            push(1, 1, m + 1 + 5*k, 40, 20 + 10*k, 1'b0, 1'b0, 1'b0);
        push(1, 1, m + 1 + 5*60, 50, 610, 1'b1, 1'b0, 1'b0);
        push(1, 1, m + 1 + 5*61, 50, 600, 1'b1, 1'b0, 1'b0);
        wait_cyc(m + 1 + 5*61 + 2);
        grid = '0;
        repeat (50) @(negedge clk);
        chk_pos("empty halt", 50, 600, 1'b1, 1'b0, 1'b0);

        // Period shrink from 54 to 5 with counter at 30: tick on next edge.
        do_reset();
        grid = {50{1'b1}};
        pulse_start(m);
        wait_cyc(m + 31);
        grid = 50'd1;
        push(1, 1, m + 32, 40, 30, 1'b0, 1'b0, 1'b0);
        push(1, 1, m + 37, 40, 40, 1'b0, 1'b0, 1'b0);
        wait_cyc(m + 38);
        do_reset();
        repeat (20) @(negedge clk);

        chk("A events left", qa.size(), 0);
        chk("B events left", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
